// File: rtl/qpsk_sample_source_pkg.sv
// QPSK sample source shared definitions.
// Level constants, FSM state encoding and the dibit-bit to level map.
package qpsk_sample_source_pkg;

    localparam int unsigned DEF_SPS = 4;
    localparam logic [7:0]  DEF_AMP = 8'd96;
    localparam logic [7:0]  DEF_MID = 8'd128;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Gray QPSK: a 0 bit maps above mid-level, a 1 bit below.
    function automatic logic [7:0] map_bit(
        input logic       b,
        input logic [7:0] mid,
        input logic [7:0] amp
    );
        return b ? (mid - amp) : (mid + amp);
    endfunction

endpackage

// File: rtl/qpsk_sample_source_byte_fifo2.sv
// Two-entry synchronous byte FIFO.
// Push is ignored when full, pop is ignored when empty.
module byte_fifo2 (
    input  logic       i_clk_x16,
    input  logic       i_rst,
    input  logic       i_push,
    input  logic [7:0] i_din,
    input  logic       i_pop,
    output logic       o_full,
    output logic       o_empty,
    output logic [7:0] o_dout
);

    logic [7:0] mem_q [2];
    logic       wr_q;
    logic       rd_q;
    logic [1:0] cnt_q;
    logic       push_w;
    logic       pop_w;

    assign o_full  = (cnt_q == 2'd2);
    assign o_empty = (cnt_q == 2'd0);
    assign o_dout  = mem_q[rd_q];
    assign push_w  = i_push && !o_full;
    assign pop_w   = i_pop && !o_empty;

    // Storage: write the entry under the write pointer.
    always_ff @(posedge i_clk_x16) begin
        if (push_w) begin
            mem_q[wr_q] <= i_din;
        end
    end

    // Pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge i_clk_x16) begin
        if (i_rst) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push_w) begin
                wr_q <= ~wr_q;
            end
            if (pop_w) begin
                rd_q <= ~rd_q;
            end
            if (push_w && !pop_w) begin
                cnt_q <= cnt_q + 2'd1;
            end else if (pop_w && !push_w) begin
                cnt_q <= cnt_q - 2'd1;
            end
        end
    end

endmodule

// File: rtl/qpsk_sample_source.sv
// QPSK sample source: bytes -> dibits -> offset-binary I/Q,
// zero-stuffed to SPS samples per symbol, paced by the FIR strobe.
module qpsk_sample_source
    import qpsk_sample_source_pkg::*;
#(
    parameter int unsigned SPS = DEF_SPS,
    parameter logic [7:0]  AMP = DEF_AMP,
    parameter logic [7:0]  MID = DEF_MID
) (
    input  logic       i_clk_x16,
    input  logic       i_rst,
    input  logic [7:0] i_byte,
    input  logic       i_byte_valid,
    output logic       o_byte_ready,
    input  logic       i_fir_ready,
    output logic [7:0] o_I,
    output logic [7:0] o_Q,
    output logic       o_active,
    output logic       o_underrun
);

    localparam int unsigned CW = $clog2(SPS);
    localparam logic [CW-1:0] LAST = CW'(SPS - 1);

    logic [CW-1:0] sample_cnt_q;
    logic [CW-1:0] sample_cnt_d;
    state_e        state_q;
    logic [1:0]    dibit_cnt_q;
    logic [5:0]    sreg_q;
    logic [7:0]    i_q;
    logic [7:0]    q_q;
    logic          underrun_q;

    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;
    logic          push_w;
    logic          slot_w;
    logic          load_w;

    byte_fifo2 u_fifo (
        .i_clk_x16 (i_clk_x16),
        .i_rst     (i_rst),
        .i_push    (push_w),
        .i_din     (i_byte),
        .i_pop     (load_w),
        .o_full    (fifo_full),
        .o_empty   (fifo_empty),
        .o_dout    (fifo_dout)
    );

    // Slot-start detection and byte-load decision for this strobe.
    always_comb begin
        sample_cnt_d = (sample_cnt_q == LAST) ? '0 : sample_cnt_q + 1'b1;
        push_w       = i_byte_valid && !fifo_full;
        slot_w       = i_fir_ready && (sample_cnt_q == '0);
        load_w       = slot_w && !fifo_empty &&
                       ((state_q == ST_IDLE) || (dibit_cnt_q == 2'd3));
    end

    // Sample phase counter, advances once per FIR strobe.
    always_ff @(posedge i_clk_x16) begin
        if (i_rst) begin
            sample_cnt_q <= '0;
        end else if (i_fir_ready) begin
            sample_cnt_q <= sample_cnt_d;
        end
    end

    // Symbol FSM with registered I/Q and underrun outputs.
    always_ff @(posedge i_clk_x16) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            dibit_cnt_q <= 2'd0;
            sreg_q      <= 6'd0;
            i_q         <= MID;
            q_q         <= MID;
            underrun_q  <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            if (i_fir_ready) begin
                if (sample_cnt_q != '0) begin
                    i_q <= MID;
                    q_q <= MID;
                end else if (load_w) begin
                    state_q     <= ST_RUN;
                    dibit_cnt_q <= 2'd0;
                    sreg_q      <= fifo_dout[5:0];
                    i_q         <= map_bit(fifo_dout[7], MID, AMP);
                    q_q         <= map_bit(fifo_dout[6], MID, AMP);
                end else begin
                    unique case (state_q)
                        ST_IDLE: begin
                            i_q <= MID;
                            q_q <= MID;
                        end
                        ST_RUN: begin
                            if (dibit_cnt_q != 2'd3) begin
                                dibit_cnt_q <= dibit_cnt_q + 2'd1;
                                sreg_q      <= {sreg_q[3:0], 2'b00};
                                i_q         <= map_bit(sreg_q[5], MID, AMP);
                                q_q         <= map_bit(sreg_q[4], MID, AMP);
                            end else begin
                                state_q    <= ST_IDLE;
                                i_q        <= MID;
                                q_q        <= MID;
                                underrun_q <= 1'b1;
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign o_byte_ready = !fifo_full;
    assign o_I          = i_q;
    assign o_Q          = q_q;
    assign o_active     = (state_q == ST_RUN);
    assign o_underrun   = underrun_q;

endmodule
